serial_word_tx: RTL and testbench

//  Parallel-to-serial frame transmitter: captures a DATA_W-bit word on a Load request
//  and shifts it out on one serial line, framed by a start bit (0) and a stop bit (1).
//  It is the sending end of the team's latch/flip-flop capture path. The serial line

---
 rtl/serial_word_tx.sv | 116 +++++++++++
 tb/tb_serial_word_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial frame transmitter: start bit (0), DATA_W payload bits LSB first,
// stop bit (1), each bit held CLKS_PER_BIT clocks by an internal divider.
module serial_word_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [DATA_W-1:0] Data_in,
    output logic              Tx,
    output logic              Busy,
    output logic              Done
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DIV_W-1:0]  r_div;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic              w_bit_end;
    logic [DATA_W-1:0] w_shift_next;

    assign w_bit_end    = (r_div == DIV_LAST);
    assign w_shift_next = r_shift >> 1;

    assign Tx   = r_tx;
    assign Busy = r_busy;
    assign Done = r_done;

    // Frame sequencer: the shift register's LSB is always the next payload bit to drive.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_shift   <= {DATA_W{1'b0}};
            r_bit_cnt <= {BIT_W{1'b0}};
            r_div     <= {DIV_W{1'b0}};
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div     <= {DIV_W{1'b0}};
                    r_bit_cnt <= {BIT_W{1'b0}};
                    if (Load) begin
                        r_shift <= Data_in;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_div     <= {DIV_W{1'b0}};
                        r_bit_cnt <= {BIT_W{1'b0}};
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_div <= r_div + DIV_W'(1'b1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_div <= {DIV_W{1'b0}};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1'b1);
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1'b1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_div   <= {DIV_W{1'b0}};
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_div <= r_div + DIV_W'(1'b1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_div     <= {DIV_W{1'b0}};
                    r_bit_cnt <= {BIT_W{1'b0}};
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (8 bits x 4 clocks, 4 bits x 1 clock)
// checked every cycle against a frame-position model, plus literal frame checks.
module tb_serial_word_tx;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Load0, Load1;
    logic [7:0] Data0;
    logic [3:0] Data1;
    logic       Tx0, Busy0, Done0;
    logic       Tx1, Busy1, Done1;

    int checks   = 0;
    int failures = 0;

    int W [2] = '{8, 4};
    int C [2] = '{4, 1};
    int m_active [2];
    int m_t      [2];
    int m_data   [2];
    int m_done   [2];

    int cnt_done0, cnt_done1, cnt_busy0;
    int rec [40];

    serial_word_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
        .Clk(Clk), .Reset(Reset), .Load(Load0), .Data_in(Data0),
        .Tx(Tx0), .Busy(Busy0), .Done(Done0)
    );

    serial_word_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Load(Load1), .Data_in(Data1),
        .Tx(Tx1), .Busy(Busy1), .Done(Done1)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0;
            m_t[i]      = 0;
            m_done[i]   = 0;
        end
    endtask

    // Frame viewed as (W+2)*C cycles measured from the accepting edge.
    task automatic model_step(input int i, input logic ld, input int din);
        int was_active;
        if (Reset) begin
            m_active[i] = 0;
            m_done[i]   = 0;
        end else begin
            was_active = m_active[i];
            m_done[i]  = 0;
            if (was_active != 0) begin
                m_t[i]++;
                if (m_t[i] == (W[i] + 2) * C[i]) begin
                    m_active[i] = 0;
                    m_done[i]   = 1;
                end
            end
            if (was_active == 0 && ld) begin
                m_active[i] = 1;
                m_t[i]      = 0;
                m_data[i]   = din;
            end
        end
    endtask

    function automatic int exp_tx(input int i);
        int b;
        if (m_active[i] == 0) return 1;
        b = m_t[i] / C[i];
        if (b == 0) return 0;
        if (b <= W[i]) return (m_data[i] >> (b - 1)) & 1;
        return 1;
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_step(0, Load0, int'(Data0));
        model_step(1, Load1, int'(Data1));
        #1;
    endtask

    task automatic run_n(input int n);
        repeat (n) begin
            @(negedge Clk);
            cnt_done0 += int'(Done0);
            cnt_done1 += int'(Done1);
            cnt_busy0 += int'(Busy0);
            tick();
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("tx0",   int'(Tx0),   exp_tx(0));
            chk("busy0", int'(Busy0), m_active[0]);
            chk("done0", int'(Done0), m_done[0]);
            chk("tx1",   int'(Tx1),   exp_tx(1));
            chk("busy1", int'(Busy1), m_active[1]);
            chk("done1", int'(Done1), m_done[1]);
        end
    end

    initial begin
        logic [9:0] seq_a5;
        logic [5:0] seq_9;
        seq_a5 = 10'b1101001010;
        seq_9  = 6'b110010;
        model_reset();
        Reset = 1'b1; Load0 = 1'b0; Load1 = 1'b0; Data0 = 8'h00; Data1 = 4'h0;
        repeat (2) tick();
        Reset = 1'b0;
        @(negedge Clk);
        chk("reset_tx", int'(Tx0), 1);
        chk("reset_busy", int'(Busy0), 0);
        chk("reset_done", int'(Done0), 0);
        tick();

        // A5 frame, bit-by-bit literal check
        Load0 = 1'b1; Data0 = 8'hA5;
        tick();
        Load0 = 1'b0; Data0 = 8'h00;
        cnt_busy0 = 0; cnt_done0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            rec[i] = int'(Tx0);
            cnt_busy0 += int'(Busy0);
            cnt_done0 += int'(Done0);
            tick();
        end
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("a5_bit%0d_first", b), rec[4*b], int'(seq_a5[b]));
            chk($sformatf("a5_bit%0d_last", b), rec[4*b+3], int'(seq_a5[b]));
        end
        chk("a5_busy_cycles", cnt_busy0, 40);
        chk("a5_no_early_done", cnt_done0, 0);
        @(negedge Clk);
        chk("a5_done", int'(Done0), 1);
        tick();
        repeat (2) tick();

        // Load during frame is ignored
        Load0 = 1'b1; Data0 = 8'hFF;
        tick();
        Load0 = 1'b0;
        cnt_busy0 = 0; cnt_done0 = 0;
        run_n(9);
        Load0 = 1'b1; Data0 = 8'h3C;
        run_n(1);
        Load0 = 1'b0;
        run_n(40);
        chk("ignore_done_count", cnt_done0, 1);
        chk("ignore_busy_cycles", cnt_busy0, 40);

        // Load held high: back-to-back frames with one idle cycle
        Load0 = 1'b1; Data0 = 8'h01;
        tick();
        Data0 = 8'h80;
        cnt_busy0 = 0; cnt_done0 = 0;
        run_n(41);
        Load0 = 1'b0;
        chk("b2b_gap_cycles", 41 - cnt_busy0, 1);
        run_n(45);
        chk("b2b_done_count", cnt_done0, 2);

        // Reset mid-frame
        Load0 = 1'b1; Data0 = 8'hAA;
        tick();
        Load0 = 1'b0;
        repeat (16) tick();
        #3;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_tx", int'(Tx0), 1);
        chk("async_rst_busy", int'(Busy0), 0);
        chk("async_rst_done", int'(Done0), 0);
        tick();
        Reset = 1'b0;
        Load0 = 1'b1; Data0 = 8'h55;
        tick();
        Load0 = 1'b0;
        cnt_done0 = 0;
        run_n(45);
        chk("post_rst_done_count", cnt_done0, 1);

        // One clock per bit, data changed after capture
        Load1 = 1'b1; Data1 = 4'b1001;
        tick();
        Load1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            rec[i] = int'(Tx1);
            if (i == 1) Data1 = 4'b0110;
            tick();
        end
        for (int b = 0; b < 6; b++)
            chk($sformatf("c1_bit%0d", b), rec[b], int'(seq_9[b]));
        @(negedge Clk);
        chk("c1_done", int'(Done1), 1);
        tick();

        // Randomised traffic on both instances
        repeat (400) begin
            Load0 = ($urandom_range(0, 7) == 0);
            Data0 = 8'($urandom);
            Load1 = ($urandom_range(0, 3) == 0);
            Data1 = 4'($urandom);
            tick();
        end
        Load0 = 1'b0; Load1 = 1'b0;
        repeat (50) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
